// File: rtl/spi_master_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : spi_master_arbiter
// Description : Round-robin arbiter in front of a single SPI master. Each
//               granted command is sent as one frame {rw, addr, wdata}, MSB
//               first, and the read data is returned to the winner.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_master_arbiter #(
    parameter int NUM_REQ   = 2,
    parameter int ADDR_BITS = 7,
    parameter int DATA_BITS = 8,
    parameter int SCK_DIV   = 4,
    parameter int SS_GAP    = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ-1:0]             req_rw,
    input  logic [NUM_REQ*ADDR_BITS-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_BITS-1:0]   req_wdata,
    output logic                           rsp_valid,
    output logic [1:0]                     rsp_id,
    output logic [DATA_BITS-1:0]           rsp_rdata,
    output logic                           busy,
    output logic                           sck,
    output logic                           ss,
    output logic                           mosi,
    input  logic                           miso
);

    localparam int FB      = 1 + ADDR_BITS + DATA_BITS;
    localparam int CNT_MAX = (SCK_DIV > SS_GAP) ? SCK_DIV : SS_GAP;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int BIT_W   = $clog2(FB + 1);

    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(SCK_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(SS_GAP - 1);
    localparam logic [BIT_W-1:0] FB_CNT   = BIT_W'(FB);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] SETUP = 3'd1;
    localparam logic [2:0] SHIFT = 3'd2;
    localparam logic [2:0] HOLD  = 3'd3;
    localparam logic [2:0] GAP   = 3'd4;

    logic [2:0]           state;
    logic [CNT_W-1:0]     div_cnt;
    logic [BIT_W-1:0]     bit_cnt;
    logic [FB-1:0]        tx_shift;
    logic [DATA_BITS-1:0] rx_shift;
    logic [1:0]           cur_id;
    logic                 cur_rw;
    logic [1:0]           last_id;

    // Requester payloads padded to four slots so a 2-bit id can index them.
    logic [ADDR_BITS-1:0] addr_arr [4];
    logic [DATA_BITS-1:0] data_arr [4];
    logic [3:0]           rw_pad;

    for (genvar g = 0; g < 4; g++) begin : g_pad
        if (g < NUM_REQ) begin : g_used
            assign addr_arr[g] = req_addr[g*ADDR_BITS +: ADDR_BITS];
            assign data_arr[g] = req_wdata[g*DATA_BITS +: DATA_BITS];
            assign rw_pad[g]   = req_rw[g];
        end else begin : g_unused
            assign addr_arr[g] = '0;
            assign data_arr[g] = '0;
            assign rw_pad[g]   = 1'b0;
        end
    end

    logic [3:0]    valid_pad;
    logic [3:0]    grant_pad;
    logic [1:0]    win_id;
    logic          any_win;
    logic [2:0]    cand;
    logic [FB-1:0] tx_word;

    // Round-robin search starting just after the last granted requester.
    always_comb begin
        valid_pad = 4'(req_valid);
        grant_pad = '0;
        win_id    = last_id;
        any_win   = 1'b0;
        cand      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, last_id} + 3'(i + 1);
            if (cand >= 3'(NUM_REQ)) begin
                cand = cand - 3'(NUM_REQ);
            end
            if (!any_win && valid_pad[cand[1:0]]) begin
                any_win = 1'b1;
                win_id  = cand[1:0];
            end
        end
        grant_pad[win_id] = any_win;
    end

    // Read frames drive zeros during the data phase.
    assign tx_word = {rw_pad[win_id], addr_arr[win_id],
                      rw_pad[win_id] ? {DATA_BITS{1'b0}} : data_arr[win_id]};

    assign req_ready = (reset && (state == IDLE)) ? grant_pad[NUM_REQ-1:0] : '0;
    assign busy      = (state != IDLE);

    // Frame sequencer: grant, ss setup, sck shifting, hold, inter-frame gap.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            div_cnt   <= '0;
            bit_cnt   <= '0;
            tx_shift  <= '0;
            rx_shift  <= '0;
            cur_id    <= '0;
            cur_rw    <= 1'b0;
            last_id   <= 2'(NUM_REQ - 1);
            sck       <= 1'b0;
            ss        <= 1'b1;
            mosi      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_win) begin
                        state    <= SETUP;
                        ss       <= 1'b0;
                        tx_shift <= tx_word;
                        mosi     <= tx_word[FB-1];
                        cur_id   <= win_id;
                        last_id  <= win_id;
                        cur_rw   <= rw_pad[win_id];
                        div_cnt  <= '0;
                        bit_cnt  <= '0;
                    end
                end
                SETUP: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt  <= '0;
                        sck      <= 1'b1;
                        bit_cnt  <= BIT_W'(1);
                        rx_shift <= {rx_shift[DATA_BITS-2:0], miso};
                        state    <= SHIFT;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                SHIFT: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        if (sck) begin
                            sck <= 1'b0;
                            if (bit_cnt == FB_CNT) begin
                                state <= HOLD;
                            end else begin
                                tx_shift <= tx_shift << 1;
                                mosi     <= tx_shift[FB-2];
                            end
                        end else begin
                            sck      <= 1'b1;
                            bit_cnt  <= bit_cnt + 1'b1;
                            rx_shift <= {rx_shift[DATA_BITS-2:0], miso};
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                HOLD: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt   <= '0;
                        ss        <= 1'b1;
                        mosi      <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_id    <= cur_id;
                        rsp_rdata <= cur_rw ? rx_shift : '0;
                        state     <= GAP;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                GAP: begin
                    if (div_cnt == GAP_LAST) begin
                        div_cnt <= '0;
                        state   <= IDLE;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_master_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_master_arbiter
// Description : Directed self-checking bench for spi_master_arbiter with a
//               passive SPI slave model and a small-divider second instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_master_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [1:0]  req_valid, req_ready, req_rw;
    logic [13:0] req_addr;
    logic [15:0] req_wdata;
    logic        rsp_valid;
    logic [1:0]  rsp_id;
    logic [7:0]  rsp_rdata;
    logic        busy, sck, ss, mosi, miso;

    logic [1:0]  b_req_valid, b_req_ready, b_req_rw;
    logic [13:0] b_req_addr;
    logic [15:0] b_req_wdata;
    logic        b_rsp_valid;
    logic [1:0]  b_rsp_id;
    logic [7:0]  b_rsp_rdata;
    logic        b_busy, b_sck, b_ss, b_mosi;
    logic        b_miso = 1'b0;

    spi_master_arbiter dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_rw(req_rw), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_rdata(rsp_rdata),
        .busy(busy), .sck(sck), .ss(ss), .mosi(mosi), .miso(miso)
    );

    spi_master_arbiter #(.SCK_DIV(1), .SS_GAP(2)) dut_fast (
        .clk(clk), .reset(reset), .req_valid(b_req_valid), .req_ready(b_req_ready),
        .req_rw(b_req_rw), .req_addr(b_req_addr), .req_wdata(b_req_wdata),
        .rsp_valid(b_rsp_valid), .rsp_id(b_rsp_id), .rsp_rdata(b_rsp_rdata),
        .busy(b_busy), .sck(b_sck), .ss(b_ss), .mosi(b_mosi), .miso(b_miso)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- passive slave / bus monitor on the main instance -------
    logic        prev_sck = 1'b0, prev_ss = 1'b1;
    int          mon_rises = 0, mon_falls = 0, ss_low_cnt = 0, ss_high_cnt = 0;
    int          last_ss_low = 0, min_gap = 1000000, rsp_cnt = 0;
    logic [15:0] mon_frame = '0, last_frame = '0;
    logic [1:0]  last_rsp_id = '0;
    logic [7:0]  last_rsp_rdata = '0;
    logic        last_rsp_ss = 1'b0, last_rsp_busy = 1'b0;
    logic [7:0]  miso_byte = '0;
    logic [7:0]  slave_regs [128];
    int          grant_ids[$];
    int          grant_cycs[$];

    // Sample the bus 1 time unit after the falling clock edge.
    always @(negedge clk) begin
        #1;
        if (!reset) begin
            mon_rises  = 0;
            mon_falls  = 0;
            ss_low_cnt = 0;
            miso       = 1'b0;
            prev_sck   = 1'b0;
            prev_ss    = 1'b1;
        end else begin
            if (!ss && prev_ss) begin
                if (ss_high_cnt < min_gap) min_gap = ss_high_cnt;
                mon_rises  = 0;
                mon_falls  = 0;
                mon_frame  = '0;
                ss_low_cnt = 0;
                miso       = 1'b0;
            end
            if (ss && !prev_ss) begin
                last_ss_low = ss_low_cnt;
                last_frame  = mon_frame;
                ss_high_cnt = 0;
                miso        = 1'b0;
                if (mon_rises == 16 && !mon_frame[15]) slave_regs[mon_frame[14:8]] = mon_frame[7:0];
            end
            if (!ss) ss_low_cnt++;
            else     ss_high_cnt++;
            if (sck && !prev_sck) begin
                mon_frame = {mon_frame[14:0], mosi};
                mon_rises++;
            end
            if (!sck && prev_sck) begin
                if (mon_falls >= 7 && mon_falls <= 14) miso = miso_byte[14 - mon_falls];
                mon_falls++;
            end
            if (rsp_valid) begin
                rsp_cnt++;
                last_rsp_id    = rsp_id;
                last_rsp_rdata = rsp_rdata;
                last_rsp_ss    = ss;
                last_rsp_busy  = busy;
            end
            if (|(req_valid & req_ready)) begin
                grant_ids.push_back(req_ready[1] ? 1 : 0);
                grant_cycs.push_back(cyc);
            end
            prev_sck = sck;
            prev_ss  = ss;
        end
    end

    // Present one command, wait for its grant, then withdraw it.
    task automatic issue(input int id, input logic rw, input logic [6:0] addr,
                         input logic [7:0] wdata, input bit scramble);
        bit got = 1'b0;
        @(negedge clk);
        req_rw[id]            = rw;
        req_addr[id*7 +: 7]   = addr;
        req_wdata[id*8 +: 8]  = wdata;
        req_valid[id]         = 1'b1;
        for (int t = 0; t < 400 && !got; t++) begin
            #1;
            if (req_ready[id]) got = 1'b1;
            else @(negedge clk);
        end
        check("grant_seen", got, 1);
        @(negedge clk);
        req_valid[id] = 1'b0;
        if (scramble) begin
            req_rw[id]           = ~rw;
            req_addr[id*7 +: 7]  = ~addr;
            req_wdata[id*8 +: 8] = ~wdata;
        end
    endtask

    task automatic wait_rsp(input int start);
        bit got = 1'b0;
        for (int t = 0; t < 600 && !got; t++) begin
            @(posedge clk);
            if (rsp_cnt != start) got = 1'b1;
        end
        check("rsp_seen", got, 1);
        for (int t = 0; t < 20 && busy; t++) @(posedge clk);
        @(negedge clk);
    endtask

    typedef struct {
        int         id;
        logic       rw;
        logic [6:0] addr;
        logic [7:0] wdata;
        logic [7:0] sdo;
        logic [15:0] exp_frame;
        logic [7:0] exp_rdata;
    } vec_t;

    vec_t vecs [6];

    logic [15:0] b_frame;
    int          b_rises, b_low, b_r0, b_r1, start;
    bit          b_got, got;
    logic [1:0]  b_id;
    logic [7:0]  b_rd;
    logic        bp;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{0, 1'b0, 7'h15, 8'h12, 8'h00, 16'h1512, 8'h00};
        vecs[1] = '{1, 1'b1, 7'h15, 8'h00, 8'hA5, 16'h9500, 8'hA5};
        vecs[2] = '{1, 1'b0, 7'h2A, 8'h3C, 8'hFF, 16'h2A3C, 8'h00};
        vecs[3] = '{0, 1'b1, 7'h7F, 8'hEE, 8'h5A, 16'hFF00, 8'h5A};
        vecs[4] = '{0, 1'b0, 7'h00, 8'h00, 8'h00, 16'h0000, 8'h00};
        vecs[5] = '{1, 1'b0, 7'h01, 8'hFF, 8'h00, 16'h01FF, 8'h00};

        reset = 1'b0;
        req_valid = '0; req_rw = '0; req_addr = '0; req_wdata = '0;
        b_req_valid = '0; b_req_rw = '0; b_req_addr = '0; b_req_wdata = '0;
        repeat (3) @(negedge clk);
        check("rst_ss", ss, 1);
        check("rst_sck", sck, 0);
        check("rst_mosi", mosi, 0);
        check("rst_req_ready", req_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_id", rsp_id, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        check("rst_busy", busy, 0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Table of single transactions
        for (int v = 0; v < 6; v++) begin
            miso_byte = vecs[v].sdo;
            start = rsp_cnt;
            issue(vecs[v].id, vecs[v].rw, vecs[v].addr, vecs[v].wdata, 1'b0);
            wait_rsp(start);
            check("frame", last_frame, vecs[v].exp_frame);
            check("ss_low_len", last_ss_low, 132);
            check("rsp_id", last_rsp_id, vecs[v].id);
            check("rsp_rdata", last_rsp_rdata, vecs[v].exp_rdata);
            check("rsp_with_ss_high", last_rsp_ss, 1);
            check("busy_at_rsp", last_rsp_busy, 1);
        end
        check("slave_reg_15", slave_regs[7'h15], 8'h12);
        check("slave_reg_2a", slave_regs[7'h2A], 8'h3C);

        // Contention: both requesters hold valid for eight commands
        grant_ids.delete();
        grant_cycs.delete();
        min_gap = 1000000;
        start = rsp_cnt;
        miso_byte = 8'h00;
        @(negedge clk);
        req_rw = 2'b00;
        req_addr = {7'h20, 7'h10};
        req_wdata = {8'hB2, 8'hB1};
        req_valid = 2'b11;
        for (int t = 0; t < 1600 && grant_ids.size() < 8; t++) @(posedge clk);
        @(negedge clk);
        req_valid = 2'b00;
        check("contention_grants", grant_ids.size(), 8);
        for (int t = 0; t < 600 && rsp_cnt < start + 8; t++) @(posedge clk);
        check("contention_rsps", rsp_cnt - start, 8);
        for (int i = 0; i < 8 && i < grant_ids.size(); i++) check("rr_order", grant_ids[i], i % 2);
        for (int i = 0; i + 1 < grant_cycs.size(); i++)
            check("grant_spacing", grant_cycs[i+1] - grant_cycs[i], 137);
        check("ss_gap_cycles", min_gap, 5);
        check("slave_reg_20", slave_regs[7'h20], 8'hB2);
        for (int t = 0; t < 20 && busy; t++) @(posedge clk);

        // Reset in the middle of a frame
        miso_byte = 8'h00;
        issue(0, 1'b0, 7'h0A, 8'h55, 1'b0);
        got = 1'b0;
        for (int t = 0; t < 200 && !got; t++) begin
            @(posedge clk);
            if (mon_rises >= 5) got = 1'b1;
        end
        check("fifth_rise_seen", got, 1);
        @(negedge clk);
        start = rsp_cnt;
        reset = 1'b0;
        #1;
        check("midrst_ss", ss, 1);
        check("midrst_sck", sck, 0);
        check("midrst_busy", busy, 0);
        repeat (10) @(negedge clk);
        reset = 1'b1;
        check("midrst_no_rsp", rsp_cnt, start);
        @(negedge clk);
        req_rw = 2'b00;
        req_addr = {7'h22, 7'h11};
        req_wdata = {8'h66, 8'h77};
        req_valid = 2'b11;
        #1;
        check("post_rst_first_grant", req_ready, 2'b01);
        @(negedge clk);
        req_valid = 2'b00;
        wait_rsp(start);
        check("post_rst_rsp_id", last_rsp_id, 0);
        check("post_rst_frame", last_frame, 16'h1177);

        // Payload changes after grant must not reach the wire
        start = rsp_cnt;
        issue(0, 1'b0, 7'h33, 8'h44, 1'b1);
        wait_rsp(start);
        check("stable_frame", last_frame, 16'h3344);
        check("stable_rdata", last_rsp_rdata, 0);
        check("slave_reg_33", slave_regs[7'h33], 8'h44);

        // Fastest divider on the second instance
        @(negedge clk);
        b_req_rw = 2'b00;
        b_req_addr[6:0] = 7'h7F;
        b_req_wdata[7:0] = 8'hFF;
        b_req_valid = 2'b01;
        got = 1'b0;
        for (int t = 0; t < 50 && !got; t++) begin
            #1;
            if (b_req_ready[0]) got = 1'b1;
            else @(negedge clk);
        end
        check("fast_grant", got, 1);
        @(negedge clk);
        b_req_valid = 2'b00;
        b_frame = '0; b_rises = 0; b_low = 0; b_r0 = 0; b_r1 = 0;
        b_got = 1'b0; b_id = 2'b11; b_rd = 8'hFF; bp = 1'b0;
        for (int t = 0; t < 100; t++) begin
            if (!b_ss) b_low++;
            if (b_sck && !bp) begin
                b_frame = {b_frame[14:0], b_mosi};
                if (b_rises == 0) b_r0 = cyc;
                if (b_rises == 1) b_r1 = cyc;
                b_rises++;
            end
            bp = b_sck;
            if (b_rsp_valid) begin
                b_got = 1'b1;
                b_id  = b_rsp_id;
                b_rd  = b_rsp_rdata;
            end
            @(negedge clk);
        end
        check("fast_frame", b_frame, 16'h7FFF);
        check("fast_rises", b_rises, 16);
        check("fast_ss_low", b_low, 33);
        check("fast_sck_period", b_r1 - b_r0, 2);
        check("fast_rsp", b_got, 1);
        check("fast_rsp_id", b_id, 0);
        check("fast_rsp_rdata", b_rd, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
